mem_bus_arbiter: RTL

//  Shares one req/gnt/rvalid memory bus between the fetch-stage instruction port and the

---
 rtl/mem_bus_arbiter.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single req/gnt/rvalid memory bus.
// An in-order ID queue routes each response back to its owner; flushed fetch responses are dropped.
module mem_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        instr_flush_i,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        proto_err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);
  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  typedef enum logic [1:0] {
    LK_NONE  = 2'd0,
    LK_INSTR = 2'd1,
    LK_DATA  = 2'd2
  } lock_e;

  lock_e           lock_state_r;
  lock_e           lock_next_s;
  logic            src_s;
  logic            sel_req_s;
  logic            eligible_s;
  logic            contended_s;
  logic            grant_s;
  logic            pop_s;
  logic            head_src_s;
  logic            resp_ok_s;
  logic [SW-1:0]   starve_cnt_r;
  logic [CW-1:0]   count_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic            proto_err_r;
  logic            q_src_r  [MAX_OUTSTANDING];
  logic            q_disc_r [MAX_OUTSTANDING];
  logic            q_vld_r  [MAX_OUTSTANDING];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    if (ptr == PTR_LAST) begin
      next_ptr = {PW{1'b0}};
    end else begin
      next_ptr = ptr + PW'(1);
    end
  endfunction

  assign eligible_s  = (count_r < MAX_CNT);
  assign contended_s = instr_req_i & data_req_i;

  // Source select: lock owner first, otherwise data priority with anti-starvation override.
  always_comb begin
    src_s = SRC_D;
    case (lock_state_r)
      LK_INSTR: src_s = SRC_I;
      LK_DATA:  src_s = SRC_D;
      default: begin
        if (contended_s) begin
          src_s = (starve_cnt_r == STARVE_MAX) ? SRC_I : SRC_D;
        end else if (instr_req_i) begin
          src_s = SRC_I;
        end else begin
          src_s = SRC_D;
        end
      end
    endcase
  end

  // Bus request and grant routing; everything is forced quiet while in reset.
  always_comb begin
    sel_req_s   = (src_s == SRC_I) ? instr_req_i : data_req_i;
    mem_req_o   = ~rst & eligible_s & sel_req_s;
    grant_s     = mem_req_o & mem_gnt_i;
    instr_gnt_o = grant_s & (src_s == SRC_I);
    data_gnt_o  = grant_s & (src_s == SRC_D);
    if (src_s == SRC_I) begin
      mem_addr_o  = instr_addr_i & 32'hFFFF_FFFC;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'hF;
      mem_wdata_o = 32'h0000_0000;
    end else begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state_r <= LK_NONE;
    end else begin
      lock_state_r <= lock_next_s;
    end
  end

  // Lock next state: a stalled request pins the source until its grant.
  always_comb begin
    lock_next_s = lock_state_r;
    if (mem_req_o && !mem_gnt_i) begin
      lock_next_s = (src_s == SRC_D) ? LK_DATA : LK_INSTR;
    end else if (grant_s) begin
      lock_next_s = LK_NONE;
    end else begin
      lock_next_s = lock_state_r;
    end
  end

  // Starvation counter: counts contended data wins, cleared by any fetch grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (instr_gnt_o) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (data_gnt_o && contended_s && (starve_cnt_r != STARVE_MAX)) begin
      starve_cnt_r <= starve_cnt_r + SW'(1);
    end
  end

  assign pop_s      = mem_rvalid_i & (count_r != {CW{1'b0}});
  assign head_src_s = q_src_r[rd_ptr_r];

  // ID queue: flush marks live fetch entries, then pop/push update the ring.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        q_src_r[i]  <= 1'b0;
        q_disc_r[i] <= 1'b0;
        q_vld_r[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (instr_flush_i && q_vld_r[i] && (q_src_r[i] == SRC_I)) begin
          q_disc_r[i] <= 1'b1;
        end
      end
      if (pop_s) begin
        q_vld_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= next_ptr(rd_ptr_r);
      end
      if (grant_s) begin
        q_vld_r[wr_ptr_r]  <= 1'b1;
        q_src_r[wr_ptr_r]  <= src_s;
        q_disc_r[wr_ptr_r] <= instr_flush_i & (src_s == SRC_I);
        wr_ptr_r           <= next_ptr(wr_ptr_r);
      end
      case ({grant_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky protocol error: a response arrived with nothing outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_r <= 1'b0;
    end else if (mem_rvalid_i && (count_r == {CW{1'b0}})) begin
      proto_err_r <= 1'b1;
    end
  end

  // Response routing; a fetch response at the head during a flush is dropped too.
  always_comb begin
    resp_ok_s      = ~rst & pop_s & ~q_disc_r[rd_ptr_r]
                     & ~(instr_flush_i & (head_src_s == SRC_I));
    instr_rvalid_o = resp_ok_s & (head_src_s == SRC_I);
    data_rvalid_o  = resp_ok_s & (head_src_s == SRC_D);
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
    instr_err_o    = mem_err_i & instr_rvalid_o;
    data_err_o     = mem_err_i & data_rvalid_o;
  end

  assign proto_err_o = proto_err_r;

endmodule
